// File: rtl/key_led_pkg.sv
// Shared constants and types for the key/LED/UART bridge.
package key_led_pkg;

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_QUERY  = 2'b10;
  localparam logic [1:0] OP_MASK   = 2'b11;

  localparam logic [1:0] RSP_STATUS = 2'b10;
  localparam logic [1:0] RSP_KEY    = 2'b01;

  localparam int WAIT_HI_TIMEOUT = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_t;

endpackage

// File: rtl/key_led_uart_bridge_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; push ignored when full, pop ignored when empty.
module byte_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  wdata,
  input  logic        pop,
  output logic [7:0]  rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/key_led_uart_bridge.sv
// UART command decoder driving LEDs, key press reporter and paced TX queue.
// KEY_LED_BRIDGE_ACK_EN: SET/TOGGLE/MASK also emit a status response byte.
module key_led_uart_bridge
  import key_led_pkg::*;
#(
  parameter int KEY_NUM    = 4,
  parameter int LED_NUM    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [KEY_NUM-1:0]            key_stable,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          tx_busy,
  output logic                          tx_en,
  output logic [7:0]                    tx_data,
  output logic [LED_NUM-1:0]            led,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [2:0] HI_LAST = 3'(WAIT_HI_TIMEOUT - 1);

  logic [1:0]         opcode;
  logic [LED_NUM-1:0] led_arg;
  logic [KEY_NUM-1:0] key_arg;
  logic [KEY_NUM-1:0] key_mask, key_prev, key_pending, key_set, key_clr;
  logic               query_pending, query_set, query_clr;
  logic               push, pop, fifo_full, fifo_empty;
  logic [7:0]         push_data, fifo_rdata;
  tx_state_t          state;
  logic [2:0]         wait_cnt;

  assign opcode  = rx_data[7:6];
  assign led_arg = LED_NUM'(rx_data[5:0]);
  assign key_arg = KEY_NUM'(rx_data[5:0]);
  assign key_set = key_prev & ~key_stable & key_mask;

`ifdef KEY_LED_BRIDGE_ACK_EN
  assign query_set = rx_valid;
`else
  assign query_set = rx_valid && (opcode == OP_QUERY);
`endif

  // Status response first, then the lowest-index pending key.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    query_clr = 1'b0;
    key_clr   = '0;
    if (!fifo_full) begin
      if (query_pending) begin
        push      = 1'b1;
        push_data = {RSP_STATUS, 6'(led)};
        query_clr = 1'b1;
      end else begin
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
          if (key_pending[i]) begin
            push       = 1'b1;
            push_data  = {RSP_KEY, 3'b000, 3'(i)};
            key_clr    = '0;
            key_clr[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      led           <= '0;
      key_mask      <= '1;
      key_prev      <= '1;
      key_pending   <= '0;
      query_pending <= 1'b0;
    end else begin
      key_prev      <= key_stable;
      key_pending   <= (key_pending & ~key_clr) | key_set;
      query_pending <= (query_pending & ~query_clr) | query_set;
      if (rx_valid) begin
        case (opcode)
          OP_SET:    led      <= led_arg;
          OP_TOGGLE: led      <= led ^ led_arg;
          OP_MASK:   key_mask <= key_arg;
          default:   led      <= led;
        endcase
      end
    end
  end

  assign pop = (state == TX_IDLE) && !fifo_empty;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= TX_IDLE;
      tx_en    <= 1'b0;
      tx_data  <= '0;
      wait_cnt <= '0;
    end else begin
      tx_en <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            tx_data <= fifo_rdata;
            tx_en   <= 1'b1;
            state   <= TX_SEND;
          end
        end
        TX_SEND: begin
          wait_cnt <= '0;
          state    <= TX_WAIT_HI;
        end
        TX_WAIT_HI: begin
          if (tx_busy || wait_cnt == HI_LAST) state <= TX_WAIT_LO;
          else wait_cnt <= wait_cnt + 3'd1;
        end
        TX_WAIT_LO: begin
          if (!tx_busy) state <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_key_led_uart_bridge.sv
// Bench for key_led_uart_bridge: directed scenarios plus randomized commands/presses vs. a byte-stream model.
module tb_key_led_uart_bridge;

  localparam int KN = 4;
  localparam int LN = 4;
  localparam int FD = 8;
`ifdef KEY_LED_BRIDGE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [KN-1:0] key_stable = '1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          tx_busy = 1'b0;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic [LN-1:0] led;
  logic [$clog2(FD):0] fifo_level;

  key_led_uart_bridge #(.KEY_NUM(KN), .LED_NUM(LN), .FIFO_DEPTH(FD)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_stable(key_stable),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_en(tx_en), .tx_data(tx_data), .led(led), .fifo_level(fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]    got_q[$];
  logic [7:0]    exp_q[$];
  logic [LN-1:0] led_m  = '0;
  logic [KN-1:0] mask_m = '1;
  bit            hold_busy = 1'b0;
  int            busy_cnt = 0;
  int            max_lvl = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter stand-in: records sent bytes and stays busy for a few cycles after each strobe.
  always @(negedge sys_clk) begin
    if (tx_en) begin
      got_q.push_back(tx_data);
      busy_cnt = 3;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = hold_busy || (busy_cnt > 0);
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
  end

  function automatic void model_cmd(input logic [7:0] b);
    logic [LN-1:0] arg;
    arg = LN'(b[5:0]);
    case (b[7:6])
      2'b00: led_m  = arg;
      2'b01: led_m  = led_m ^ arg;
      2'b11: mask_m = KN'(b[5:0]);
      default: ;
    endcase
    if (b[7:6] == 2'b10 || ACK) exp_q.push_back(8'h80 + 8'(led_m));
  endfunction

  function automatic void model_press(input logic [KN-1:0] k);
    for (int i = 0; i < KN; i++)
      if (k[i] && mask_m[i]) exp_q.push_back(8'h40 + 8'(i));
  endfunction

  task automatic cmd(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    model_cmd(b);
    @(negedge sys_clk);
    rx_valid = 1'b0;
  endtask

  task automatic press(input logic [KN-1:0] k);
    key_stable = ~k;
    model_press(k);
    @(negedge sys_clk);
    key_stable = '1;
  endtask

  // Stimulus already applied at this negedge; count negedges until the first tx_en.
  task automatic wait_tx(output int lat, output logic [7:0] b);
    lat = 0;
    b   = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin
        rx_valid   = 1'b0;
        key_stable = '1;
      end
      if (tx_en) begin
        lat = k;
        b   = tx_data;
        break;
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 800) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (24) @(negedge sys_clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    check({tag, "_led"}, led, led_m);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int         lat;
    logic [7:0] b;

    repeat (3) @(negedge sys_clk);
    check("rst_tx_en", tx_en, 0);
    check("rst_level", fifo_level, 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("init_led", led, 0);
    check("init_tx_data", tx_data, 0);
    check("init_level", fifo_level, 0);

    cmd(8'h05);
    check("set_led", led, 4'b0101);
    drain("set");
    cmd(8'h43);
    check("toggle_led", led, 4'b0110);
    drain("toggle");

    rx_valid = 1'b1; rx_data = 8'h80; model_cmd(8'h80);
    wait_tx(lat, b);
    check("query_latency", lat, 3);
    check("query_byte", b, 8'h86);
    drain("query");

    key_stable = ~4'b0100; model_press(4'b0100);
    wait_tx(lat, b);
    check("key_latency", lat, 3);
    check("key_byte", b, 8'h42);
    drain("key2");

    cmd(8'hFB);
    drain("mask");
    press(4'b0100);
    repeat (50) @(negedge sys_clk);
    check("masked_quiet", got_q.size(), 0);
    got_q.delete();
    cmd(8'hFF);
    drain("unmask");

    press(4'b1001);
    drain("keys03");

    cmd(8'h01); cmd(8'h42); cmd(8'h44);
    check("burst_led", led, 4'h7);
    drain("burst");

    cmd(8'h0F);
    drain("ack");

    // Saturation: transmitter held busy while FD+3 distinct events arrive.
    hold_busy = 1'b1;
    max_lvl   = 0;
    for (int e = 0; e < FD + 3; e++) begin
      if (e % 5 == 4) cmd(8'h80);
      else press(KN'(1 << (e % 5)));
      repeat (2) @(negedge sys_clk);
    end
    repeat (6) @(negedge sys_clk);
    check("sat_level", fifo_level, FD);
    check("sat_max_level", max_lvl, FD);
    hold_busy = 1'b0;
    drain("sat");

    // Reset while waiting on the transmitter with three bytes queued.
    cmd(8'h05);
    drain("pre_rst");
    hold_busy = 1'b1;
    for (int i = 0; i < KN; i++) begin
      press(KN'(1 << i));
      repeat (2) @(negedge sys_clk);
    end
    repeat (6) @(negedge sys_clk);
    check("pre_rst_level", fifo_level, 3);
    sys_rst = 1'b1;
    #1;
    check("mid_rst_tx_en", tx_en, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_led", led, 0);
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    hold_busy = 1'b0;
    repeat (50) @(negedge sys_clk);
    check("post_rst_count", got_q.size(), 1);
    b = (got_q.size() > 0) ? got_q[0] : 8'h00;
    check("post_rst_first", b, 8'h40);
    got_q.delete();
    exp_q.delete();
    led_m  = '0;
    mask_m = '1;

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) press(KN'($urandom_range(1, 15)));
      else cmd(8'($urandom_range(0, 255)));
      drain("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
